// File: rtl/comparator_nbits_debounce_if.sv
// Operand/result bundle for the N-bit debounced comparator.
// Latency: none (wires only); results appear one cycle after the sample on the DUT side.
// Backpressure: none; the producer may assert in_valid every cycle.
interface comparator_nbits_debounce_if #(
  parameter int WIDTH = 8
) ();

  // Sample side: operands and compare mode, qualified by in_valid.
  logic             in_valid;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Result side: registered compare flags and debounced threshold events.
  logic             out_valid;
  logic             less;
  logic             equal;
  logic             greater;
  logic             above;
  logic             cross_up;
  logic             cross_down;

  // Sample producer (ADC/counter front end, or a testbench).
  modport master (
    output in_valid,
    output signed_mode,
    output a,
    output b,
    input  out_valid,
    input  less,
    input  equal,
    input  greater,
    input  above,
    input  cross_up,
    input  cross_down
  );

  // Comparator block.
  modport slave (
    input  in_valid,
    input  signed_mode,
    input  a,
    input  b,
    output out_valid,
    output less,
    output equal,
    output greater,
    output above,
    output cross_up,
    output cross_down
  );

endinterface

// File: rtl/comparator_nbits_debounce.sv
// N-bit magnitude comparator with registered less/equal/greater and a debounced "a above b" FSM.
// Latency: 1 cycle from an in_valid sample to out_valid/flags and to above/cross_up/cross_down.
// Backpressure: none; accepts a sample every cycle. Signed compare only when COMPARATOR_SIGNED_EN is defined.
module comparator_nbits_debounce #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  comparator_nbits_debounce_if.slave  bus
);

  // Run counter just wide enough for 0..DEBOUNCE-1.
  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_BELOW   = 2'd0,
    ST_RISING  = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Compare datapath
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

`ifdef COMPARATOR_SIGNED_EN
  // Flipping the sign bit of both operands maps two's complement order
  // onto unsigned order, so one unsigned comparator serves both modes.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  // Bias operands into unsigned order when the sample asks for signed.
  always_comb begin
    a_key = bus.a;
    b_key = bus.b;
    if (bus.signed_mode) begin
      a_key = bus.a ^ MSB_MASK;
      b_key = bus.b ^ MSB_MASK;
    end
  end
`else
  // Unsigned-only build: the mode pin is present but has no effect.
  logic unused_signed_mode;
  assign unused_signed_mode = bus.signed_mode;
  assign a_key = bus.a;
  assign b_key = bus.b;
`endif

  logic cmp_lt;
  logic cmp_eq;
  logic cmp_gt;
  logic hit;

  assign cmp_lt = (a_key <  b_key);
  assign cmp_eq = (a_key == b_key);
  assign cmp_gt = (a_key >  b_key);
  // Equal is deliberately a miss: the threshold must be strictly exceeded.
  assign hit    = cmp_gt;

  // ------------------------------------------------------------------
  // Result registers
  // ------------------------------------------------------------------
  logic out_valid_q;
  logic less_q;
  logic equal_q;
  logic greater_q;

  // Capture flags on valid samples; hold them across idle cycles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_valid_q <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        less_q    <= cmp_lt;
        equal_q   <= cmp_eq;
        greater_q <= cmp_gt;
      end
    end
  end

  // ------------------------------------------------------------------
  // Debounce FSM
  // ------------------------------------------------------------------
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          above_q;
  logic          cross_up_q;
  logic          cross_down_q;

  // Count consecutive valid samples disagreeing with the settled side;
  // idle cycles leave state and count untouched.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_BELOW;
      cnt_q        <= '0;
      above_q      <= 1'b0;
      cross_up_q   <= 1'b0;
      cross_down_q <= 1'b0;
    end else begin
      cross_up_q   <= 1'b0;
      cross_down_q <= 1'b0;
      if (bus.in_valid) begin
        unique case (state_q)
          ST_BELOW: begin
            if (hit) begin
              if (DEBOUNCE == 1) begin
                state_q    <= ST_ABOVE;
                cnt_q      <= '0;
                above_q    <= 1'b1;
                cross_up_q <= 1'b1;
              end else begin
                state_q <= ST_RISING;
                cnt_q   <= CNT_ONE;
              end
            end else begin
              cnt_q <= '0;
            end
          end

          ST_RISING: begin
            if (hit) begin
              if (cnt_q == CNT_LAST) begin
                state_q    <= ST_ABOVE;
                cnt_q      <= '0;
                above_q    <= 1'b1;
                cross_up_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else begin
              state_q <= ST_BELOW;
              cnt_q   <= '0;
            end
          end

          ST_ABOVE: begin
            if (!hit) begin
              if (DEBOUNCE == 1) begin
                state_q      <= ST_BELOW;
                cnt_q        <= '0;
                above_q      <= 1'b0;
                cross_down_q <= 1'b1;
              end else begin
                state_q <= ST_FALLING;
                cnt_q   <= CNT_ONE;
              end
            end else begin
              cnt_q <= '0;
            end
          end

          ST_FALLING: begin
            if (!hit) begin
              if (cnt_q == CNT_LAST) begin
                state_q      <= ST_BELOW;
                cnt_q        <= '0;
                above_q      <= 1'b0;
                cross_down_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else begin
              state_q <= ST_ABOVE;
              cnt_q   <= '0;
            end
          end

          default: begin
            state_q <= ST_BELOW;
            cnt_q   <= '0;
            above_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.less       = less_q;
  assign bus.equal      = equal_q;
  assign bus.greater    = greater_q;
  assign bus.above      = above_q;
  assign bus.cross_up   = cross_up_q;
  assign bus.cross_down = cross_down_q;

endmodule

// File: tb/tb_comparator_nbits_debounce.sv
// Bench for comparator_nbits_debounce: a 2-bit/DEBOUNCE=1 and an 8-bit/DEBOUNCE=3 instance.
// Expected outputs come from an arithmetic reference model (integer compare + run length).
// Directed test-plan sequences followed by randomized samples with occasional resets.
module tb_comparator_nbits_debounce;

`ifdef COMPARATOR_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  always #5 sys_clk = ~sys_clk;

  comparator_nbits_debounce_if #(.WIDTH(2)) i2 ();
  comparator_nbits_debounce_if #(.WIDTH(8)) i8 ();

  comparator_nbits_debounce #(.WIDTH(2), .DEBOUNCE(1)) u_w2 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (i2)
  );

  comparator_nbits_debounce #(.WIDTH(8), .DEBOUNCE(3)) u_w8 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (i8)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, index 0 = 2-bit instance, 1 = 8-bit instance.
  bit m_ov[2], m_lt[2], m_eq[2], m_gt[2], m_above[2], m_cu[2], m_cd[2];
  int m_run[2];

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sval(input int x, input int w, input bit sgn);
    if (sgn && x >= (1 << (w - 1))) return x - (1 << w);
    return x;
  endfunction

  // Behaviour: flags follow the integer compare; 'above' flips after db
  // consecutive valid samples that disagree with it, pulsing on the flip.
  task automatic model_step(input int d, input bit rst, input bit v, input bit sm,
                            input int av, input int bv, input int w, input int db);
    int x, y;
    bit h;
    if (rst) begin
      m_ov[d] = 0; m_lt[d] = 0; m_eq[d] = 0; m_gt[d] = 0;
      m_above[d] = 0; m_cu[d] = 0; m_cd[d] = 0; m_run[d] = 0;
      return;
    end
    m_ov[d] = v; m_cu[d] = 0; m_cd[d] = 0;
    if (!v) return;
    x = sval(av, w, SIGNED_EN && sm);
    y = sval(bv, w, SIGNED_EN && sm);
    m_lt[d] = (x < y); m_eq[d] = (x == y); m_gt[d] = (x > y);
    h = (x > y);
    if (h != m_above[d]) begin
      m_run[d]++;
      if (m_run[d] == db) begin
        m_above[d] = h;
        m_cu[d] = h;
        m_cd[d] = !h;
        m_run[d] = 0;
      end
    end else begin
      m_run[d] = 0;
    end
  endtask

  task automatic check_all();
    chk("w2.out_valid",  i2.out_valid,  m_ov[0]);
    chk("w2.less",       i2.less,       m_lt[0]);
    chk("w2.equal",      i2.equal,      m_eq[0]);
    chk("w2.greater",    i2.greater,    m_gt[0]);
    chk("w2.above",      i2.above,      m_above[0]);
    chk("w2.cross_up",   i2.cross_up,   m_cu[0]);
    chk("w2.cross_down", i2.cross_down, m_cd[0]);
    chk("w8.out_valid",  i8.out_valid,  m_ov[1]);
    chk("w8.less",       i8.less,       m_lt[1]);
    chk("w8.equal",      i8.equal,      m_eq[1]);
    chk("w8.greater",    i8.greater,    m_gt[1]);
    chk("w8.above",      i8.above,      m_above[1]);
    chk("w8.cross_up",   i8.cross_up,   m_cu[1]);
    chk("w8.cross_down", i8.cross_down, m_cd[1]);
  endtask

  // One clock: advance the model on the inputs being presented, then compare.
  task automatic cycle();
    model_step(0, sys_rst, i2.in_valid, i2.signed_mode, int'(i2.a), int'(i2.b), 2, 1);
    model_step(1, sys_rst, i8.in_valid, i8.signed_mode, int'(i8.a), int'(i8.b), 8, 3);
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  task automatic drive8(input bit v, input bit sm, input int av, input int bv);
    i8.in_valid    = v;
    i8.signed_mode = sm;
    i8.a           = 8'(av);
    i8.b           = 8'(bv);
  endtask

  task automatic sample8(input int av);
    drive8(1'b1, 1'b0, av, 100);
    cycle();
  endtask

  task automatic idle8(input int n);
    drive8(1'b0, 1'b0, 0, 100);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_pulse(input int n);
    sys_rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    sys_rst = 1'b0;
  endtask

  initial begin
    i2.in_valid = 1'b0; i2.signed_mode = 1'b0; i2.a = '0; i2.b = '0;
    drive8(1'b0, 1'b0, 0, 0);

    // Reset held two cycles, then five idle cycles: everything stays 0.
    reset_pulse(2);
    for (int i = 0; i < 5; i++) cycle();

    // Exhaustive 2-bit unsigned compare, back to back.
    for (int p = 0; p < 16; p++) begin
      i2.in_valid = 1'b1;
      i2.a = 2'(p >> 2);
      i2.b = 2'(p & 3);
      cycle();
      chk("w2.one_hot", 1'(int'(i2.less) + int'(i2.equal) + int'(i2.greater) == 1), 1'b1);
    end
    i2.in_valid = 1'b0;
    cycle();
    chk("w2.hold_ov0", i2.out_valid, 1'b0);

    // Signed/unsigned mode directed samples.
    drive8(1'b1, 1'b1, 8'hFF, 8'h01); cycle();
    chk("signed_ff_01_less", i8.less, SIGNED_EN);
    chk("signed_ff_01_greater", i8.greater, !SIGNED_EN);
    drive8(1'b1, 1'b1, 8'h80, 8'h7F); cycle();
    chk("signed_80_7f_less", i8.less, SIGNED_EN);
    drive8(1'b1, 1'b0, 8'hFF, 8'h01); cycle();
    chk("unsigned_ff_01_greater", i8.greater, 1'b1);
    idle8(1);
    chk("idle_holds_greater", i8.greater, 1'b1);

    // Debounce up: a broken run does not cross, three hits do.
    reset_pulse(1);
    sample8(101); sample8(102); sample8(50);
    chk("up_broken_above", i8.above, 1'b0);
    sample8(101); sample8(101);
    chk("up_two_hits_above", i8.above, 1'b0);
    sample8(101);
    chk("up_cross_pulse", i8.cross_up, 1'b1);
    chk("up_above_set", i8.above, 1'b1);
    idle8(1);
    chk("up_pulse_single", i8.cross_up, 1'b0);
    sample8(100);
    chk("equal_is_miss_above", i8.above, 1'b1);
    sample8(101);

    // Debounce down with idle gaps between misses.
    sample8(10); idle8(4); sample8(10); idle8(1);
    chk("down_gap_above", i8.above, 1'b1);
    sample8(10);
    chk("down_cross_pulse", i8.cross_down, 1'b1);
    chk("down_above_clr", i8.above, 1'b0);

    // Reset mid-run discards the partial rise; reset beats in_valid.
    sample8(101); sample8(101);
    drive8(1'b1, 1'b0, 101, 100);
    reset_pulse(1);
    chk("rst_over_valid", i8.out_valid, 1'b0);
    sample8(101);
    chk("rst_run_no_cross", i8.cross_up, 1'b0);
    sample8(101);
    chk("rst_run_no_cross2", i8.cross_up, 1'b0);
    sample8(101);
    chk("rst_run_cross", i8.cross_up, 1'b1);

    // Randomized samples on both instances with occasional resets.
    for (int i = 0; i < 800; i++) begin
      sys_rst        = ($urandom_range(0, 79) == 0);
      i2.in_valid    = ($urandom_range(0, 9) < 7);
      i2.signed_mode = 1'($urandom);
      i2.a           = 2'($urandom);
      i2.b           = 2'($urandom);
      drive8($urandom_range(0, 9) < 7, 1'($urandom),
             int'($urandom_range(0, 255)), int'($urandom_range(64, 192)));
      cycle();
    end
    sys_rst = 1'b0;
    i2.in_valid = 1'b0;
    idle8(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/comparator_nbits_debounce.md
# comparator_nbits_debounce

Parametrised N-bit magnitude comparator with registered less/equal/greater outputs and a valid handshake. It adds a debounced "a above b" state machine that emits single-cycle crossing pulses. It is the general-width successor to the 2-bit combinational comparator and sits between a sampled data source (ADC/counter) and control logic that needs glitch-free threshold events.

## Interface
- WIDTH, 8 — operand width in bits; legal range 1..32.
- DEBOUNCE, 4 — consecutive valid samples required to change the `above` state; legal range 1..255.
- sys_clk  in  1  sole clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a/b/signed_mode are sampled this cycle.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned (see Configuration).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (threshold).
- out_valid  out  1  registered copy of in_valid.
- less  out  1  A < B for the sample flagged by out_valid.
- equal  out  1  A == B for that sample.
- greater  out  1  A > B for that sample.
- above  out  1  debounced state; 1 = in ABOVE/FALLING.
- cross_up  out  1  one-cycle pulse on BELOW-side → ABOVE transition.
- cross_down  out  1  one-cycle pulse on ABOVE-side → BELOW transition.

## Operation
- Compare: on a cycle with in_valid=1, exactly one of less/equal/greater is computed and registered; out_valid=1 next cycle. When in_valid=0, out_valid=0 next cycle and less/equal/greater hold their previous values.
- Signed compare: operands are interpreted as WIDTH-bit two's complement; e.g. WIDTH=8, 8'hFF (-1) < 8'h01.
- FSM states: BELOW, RISING, ABOVE, FALLING; a counter cnt of width $clog2(DEBOUNCE+1).
- "hit" = valid sample with A > B; "miss" = valid sample with A <= B (equal counts as miss).
- BELOW: hit → cnt=1, go RISING (or, if DEBOUNCE=1, directly to ABOVE with cross_up). Miss → stay, cnt=0.
- RISING: hit → cnt+1; when cnt+1 == DEBOUNCE → ABOVE, cnt=0, cross_up. Miss → BELOW, cnt=0.
- ABOVE: miss → cnt=1, go FALLING (or, if DEBOUNCE=1, directly to BELOW with cross_down). Hit → stay.
- FALLING: miss → cnt+1; when cnt+1 == DEBOUNCE → BELOW, cnt=0, cross_down. Hit → ABOVE, cnt=0.
- Cycles with in_valid=0 leave state and cnt unchanged; they neither break nor extend a run.
- above = 1 in ABOVE and FALLING; 0 in BELOW and RISING.
- cnt never exceeds DEBOUNCE-1 and never wraps.

## Timing
- Reset (sys_rst=1 at an edge): state=BELOW, cnt=0. All outputs are 0 after that edge, including equal. Reset overrides in_valid in the same cycle.
- Reset mid-run (e.g. in RISING with cnt=2) discards the run; no cross pulse is generated.
- Latency: 1 cycle from an in_valid sample to out_valid/less/equal/greater. The FSM consumes the same sample in the same edge, so above/cross_up/cross_down change in the out_valid cycle of the deciding sample.
- cross_up and cross_down are high for exactly one cycle and are never high together. They fire only in a cycle where out_valid=1.
- Back-to-back in_valid every cycle is supported; there is no backpressure.

## Configuration
- COMPARATOR_SIGNED_EN defined: the signed_mode input is honoured per sample; the mode is captured with the operands when in_valid=1.
- COMPARATOR_SIGNED_EN undefined: the signed_mode port still exists but is ignored. All compares are unsigned and no signed logic is synthesised.

## Test plan
- Reset then idle: after sys_rst is held 2 cycles and released, all outputs are 0 for 5 idle cycles.
- Exhaustive compare, WIDTH=2, unsigned: all 16 (a,b) pairs from 00/00 to 11/11 with in_valid=1 each cycle → one cycle later exactly one of less/equal/greater is set, correct for each pair.
- Signed compare, WIDTH=8, macro defined, signed_mode=1:
  - a=8'hFF, b=8'h01 → less=1.
  - a=8'h80, b=8'h7F → less=1.
  - With signed_mode=0, a=8'hFF, b=8'h01 → greater=1.
  - Macro undefined, signed_mode=1, a=8'hFF, b=8'h01 → greater=1.
- Debounce up, DEBOUNCE=3, b=8'd100:
  - Samples a=101,102,50 → above stays 0, no pulse.
  - Then a=101,101,101 → cross_up=1 in the out_valid cycle of the 3rd sample; above=1 from then on.
  - Equal sample a=100 counts as a miss.
- Debounce down with gaps, DEBOUNCE=3, starting from ABOVE: a=10, idle 4 cycles, a=10, idle, a=10 → cross_down fires on the 3rd valid miss only; above goes to 0 on the same cycle.
- Reset mid-run, DEBOUNCE=3: two hits (RISING, cnt=2), then sys_rst for 1 cycle, then one hit → no cross_up. Two further hits are needed before cross_up asserts.
